// File: rtl/ktane_timer_pkg.sv
// Shared definitions for the bomb countdown timer peripheral:
// FSM state encodings, register offsets, CTRL bit positions,
// the active-low seven-segment table and small helper functions.
package ktane_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUNNING  = 2'd1,
    ST_EXPLODED = 2'd2,
    ST_DEFUSED  = 2'd3
  } state_e;

  // Word offsets from BASE_ADDR
  localparam int unsigned REG_CTRL   = 0;
  localparam int unsigned REG_TIME   = 1;
  localparam int unsigned REG_STATUS = 2;

  // CTRL bit indices (self-clearing command strobes)
  localparam int unsigned CTRL_START  = 0;
  localparam int unsigned CTRL_STOP   = 1;
  localparam int unsigned CTRL_STRIKE = 2;
  localparam int unsigned CTRL_DEFUSE = 3;
  localparam int unsigned CTRL_CLEAR  = 4;
  localparam int unsigned CTRL_W      = 5;

  localparam int unsigned SEG_W = 7;

  // Active-low {g,f,e,d,c,b,a}; entry [d] is the pattern for digit d
  localparam logic [9:0][SEG_W-1:0] SEVSEG_TABLE = {
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

  // Thermometer code of the strike count
  function automatic logic [2:0] strike_therm(input logic [1:0] s);
    case (s)
      2'd0:    strike_therm = 3'b000;
      2'd1:    strike_therm = 3'b001;
      2'd2:    strike_therm = 3'b011;
      default: strike_therm = 3'b111;
    endcase
  endfunction

  // Saturate a written BCD digit to lim
  function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] lim);
    clamp_digit = (d > lim) ? lim : d;
  endfunction

endpackage

// File: rtl/ktane_timer_periph_bcd_to_sevseg.sv
// BCD digit to active-low seven-segment decoder.
// Ports: digit (4-bit BCD in), seg (7-bit active-low {g,f,e,d,c,b,a} out).
// Non-decimal codes blank the digit.
module bcd_to_sevseg
  import ktane_timer_pkg::*;
(
  input  logic [3:0]       digit,
  output logic [SEG_W-1:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (digit)
      4'd0: seg = SEVSEG_TABLE[0];
      4'd1: seg = SEVSEG_TABLE[1];
      4'd2: seg = SEVSEG_TABLE[2];
      4'd3: seg = SEVSEG_TABLE[3];
      4'd4: seg = SEVSEG_TABLE[4];
      4'd5: seg = SEVSEG_TABLE[5];
      4'd6: seg = SEVSEG_TABLE[6];
      4'd7: seg = SEVSEG_TABLE[7];
      4'd8: seg = SEVSEG_TABLE[8];
      4'd9: seg = SEVSEG_TABLE[9];
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/ktane_timer_periph.sv
// Memory-mapped bomb countdown timer and strike counter.
// Registers (word offsets from BASE_ADDR): +0 CTRL (write-only strobes),
// +1 TIME (BCD M:SS, writable only in IDLE), +2 STATUS {state, strikes}.
// Ports: clock, reset (sync, active-low); CPU write side data/write_addr/we;
// CPU read side read_addr/re -> q (1-cycle registered latency);
// timer_sevseg1..3 (combinational from the time register, M / S10 / S1);
// strike_leds (thermometer); exploded (high in EXPLODED).
// Optional: define KTANE_TIMER_STRIKE_SPEEDUP_EN to shorten the countdown
// second by a quarter per strike.
module ktane_timer_periph
  import ktane_timer_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 50000000,
  parameter logic [15:0] BASE_ADDR   = 16'hFF00,
  parameter logic [11:0] START_TIME  = 12'h500,
  parameter int unsigned MAX_STRIKES = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [15:0]      data,
  input  logic [15:0]      write_addr,
  input  logic             we,
  input  logic [15:0]      read_addr,
  input  logic             re,
  output logic [15:0]      q,
  output logic [SEG_W-1:0] timer_sevseg1,
  output logic [SEG_W-1:0] timer_sevseg2,
  output logic [SEG_W-1:0] timer_sevseg3,
  output logic [2:0]       strike_leds,
  output logic             exploded
);

  localparam int unsigned PW      = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int unsigned TC_FULL = CLK_HZ - 1;
  localparam int unsigned QUARTER = CLK_HZ / 4;
  localparam logic [1:0]  MAX_S   = 2'(MAX_STRIKES);

  localparam logic [15:0] ADDR_CTRL   = BASE_ADDR + 16'(REG_CTRL);
  localparam logic [15:0] ADDR_TIME   = BASE_ADDR + 16'(REG_TIME);
  localparam logic [15:0] ADDR_STATUS = BASE_ADDR + 16'(REG_STATUS);

  state_e         state;
  logic [11:0]    time_bcd;
  logic [1:0]     strikes;
  logic [PW-1:0]  presc;

  logic [CTRL_W-1:0] ctrl;
  logic              time_wr;
  logic [11:0]       time_wr_val;
  logic [11:0]       time_dec;
  logic [31:0]       term_count;
  logic              tick;
  logic              time_zero;
  logic              run_timeout;
  logic [1:0]        strike_inc;
  logic              strike_max;
  logic [15:0]       rd_data;
  logic              unused_data_bits;

  // Only the low CTRL bits and the 12 BCD bits of a write carry meaning
  assign unused_data_bits = ^data[15:12];

  // Write decode; CTRL strobes exist only for the cycle they are written
  assign ctrl        = (we && write_addr == ADDR_CTRL) ? data[CTRL_W-1:0] : '0;
  assign time_wr     = we && (write_addr == ADDR_TIME);
  assign time_wr_val = {clamp_digit(data[11:8], 4'd9),
                        clamp_digit(data[7:4],  4'd5),
                        clamp_digit(data[3:0],  4'd9)};

  // Prescaler terminal count; >= lets a strike that lowers it mid-second tick at once
`ifdef KTANE_TIMER_STRIKE_SPEEDUP_EN
  assign term_count = 32'(TC_FULL) - 32'(QUARTER) * 32'(strikes);
`else
  assign term_count = 32'(TC_FULL);
`endif

  assign tick      = (state == ST_RUNNING) && (32'(presc) >= term_count);
  assign time_zero = (time_bcd == 12'h000);

  // BCD M:SS decrement with borrow S1 -> S10 -> M
  always_comb begin
    time_dec = time_bcd;
    if (time_bcd[3:0] != 4'd0) begin
      time_dec[3:0] = time_bcd[3:0] - 4'd1;
    end else begin
      time_dec[3:0] = 4'd9;
      if (time_bcd[7:4] != 4'd0) begin
        time_dec[7:4] = time_bcd[7:4] - 4'd1;
      end else begin
        time_dec[7:4]  = 4'd5;
        time_dec[11:8] = time_bcd[11:8] - 4'd1;
      end
    end
  end

  // Already at 0:00 (started from zero) or this tick reaches it
  assign run_timeout = time_zero || (tick && time_dec == 12'h000);

  assign strike_inc = (strikes >= MAX_S) ? strikes : strikes + 2'd1;
  assign strike_max = ctrl[CTRL_STRIKE] && (strike_inc == MAX_S);

  // Read mux; CTRL and unmapped addresses read as zero
  always_comb begin
    rd_data = '0;
    if (read_addr == ADDR_TIME) begin
      rd_data = {4'b0, time_bcd};
    end else if (read_addr == ADDR_STATUS) begin
      rd_data = {12'b0, state, strikes};
    end
  end

  // Controller FSM with datapath registers and registered outputs
  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= ST_IDLE;
      time_bcd    <= START_TIME;
      strikes     <= '0;
      presc       <= '0;
      q           <= '0;
      strike_leds <= '0;
      exploded    <= 1'b0;
    end else begin
      if (re) begin
        q <= rd_data;
      end

      if (ctrl[CTRL_CLEAR]) begin
        state       <= ST_IDLE;
        time_bcd    <= START_TIME;
        strikes     <= '0;
        presc       <= '0;
        strike_leds <= '0;
        exploded    <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (time_wr) begin
              time_bcd <= time_wr_val;
            end
            if (ctrl[CTRL_STRIKE]) begin
              strikes     <= strike_inc;
              strike_leds <= strike_therm(strike_inc);
            end
            if (strike_max) begin
              state    <= ST_EXPLODED;
              exploded <= 1'b1;
            end else if (ctrl[CTRL_START]) begin
              state <= ST_RUNNING;
            end
          end

          ST_RUNNING: begin
            presc <= tick ? '0 : presc + PW'(1);
            if (tick && !time_zero) begin
              time_bcd <= time_dec;
            end
            if (ctrl[CTRL_STRIKE]) begin
              strikes     <= strike_inc;
              strike_leds <= strike_therm(strike_inc);
            end
            // Explosion outranks DEFUSE, which outranks STOP
            if (run_timeout || strike_max) begin
              state    <= ST_EXPLODED;
              exploded <= 1'b1;
            end else if (ctrl[CTRL_DEFUSE]) begin
              state <= ST_DEFUSED;
            end else if (ctrl[CTRL_STOP]) begin
              state <= ST_IDLE;
            end
          end

          default: begin
            // EXPLODED / DEFUSED are terminal until CLEAR
          end
        endcase
      end
    end
  end

  bcd_to_sevseg u_seg_min  (.digit(time_bcd[11:8]), .seg(timer_sevseg1));
  bcd_to_sevseg u_seg_s10  (.digit(time_bcd[7:4]),  .seg(timer_sevseg2));
  bcd_to_sevseg u_seg_s1   (.digit(time_bcd[3:0]),  .seg(timer_sevseg3));

endmodule

// File: tb/tb_ktane_timer_periph.sv
// Self-checking bench for ktane_timer_periph with CLK_HZ=4.
// Read expectations are queued when a read is issued and compared when q updates.
module tb_ktane_timer_periph;

  localparam int unsigned CLK_HZ   = 4;
  localparam logic [15:0] A_CTRL   = 16'hFF00;
  localparam logic [15:0] A_TIME   = 16'hFF01;
  localparam logic [15:0] A_STATUS = 16'hFF02;

  localparam logic [15:0] C_START  = 16'h0001;
  localparam logic [15:0] C_STOP   = 16'h0002;
  localparam logic [15:0] C_STRIKE = 16'h0004;
  localparam logic [15:0] C_DEFUSE = 16'h0008;
  localparam logic [15:0] C_CLEAR  = 16'h0010;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] data = '0;
  logic [15:0] write_addr = '0;
  logic        we = 1'b0;
  logic [15:0] read_addr = '0;
  logic        re = 1'b0;
  logic [15:0] q;
  logic [6:0]  timer_sevseg1, timer_sevseg2, timer_sevseg3;
  logic [2:0]  strike_leds;
  logic        exploded;

  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] exp_q[$];

  ktane_timer_periph #(
    .CLK_HZ(CLK_HZ), .BASE_ADDR(16'hFF00), .START_TIME(12'h500), .MAX_STRIKES(3)
  ) dut (
    .clock(clock), .reset(reset), .data(data), .write_addr(write_addr), .we(we),
    .read_addr(read_addr), .re(re), .q(q),
    .timer_sevseg1(timer_sevseg1), .timer_sevseg2(timer_sevseg2),
    .timer_sevseg3(timer_sevseg3), .strike_leds(strike_leds), .exploded(exploded)
  );

  always #5 clock = ~clock;

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: seg_of = 7'b1000000;
      1: seg_of = 7'b1111001;
      2: seg_of = 7'b0100100;
      3: seg_of = 7'b0110000;
      4: seg_of = 7'b0011001;
      5: seg_of = 7'b0010010;
      6: seg_of = 7'b0000010;
      7: seg_of = 7'b1111000;
      8: seg_of = 7'b0000000;
      default: seg_of = 7'b0010000;
    endcase
  endfunction

  // Advance n rising edges, leaving inputs/outputs 1 time unit past the edge
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic wr(input logic [15:0] addr, input logic [15:0] d);
    we = 1'b1; write_addr = addr; data = d;
    step(1);
    we = 1'b0; data = '0;
  endtask

  task automatic rd(input logic [15:0] addr, input logic [15:0] expv, input string name);
    logic [15:0] e;
    exp_q.push_back(expv);
    re = 1'b1; read_addr = addr;
    step(1);
    re = 1'b0;
    e = exp_q.pop_front();
    n_tests++;
    if (q !== e) begin
      n_fail++;
      $display("FAIL %s: q=%h expected %h", name, q, e);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step(2);
    reset = 1'b1;
    step(1);
    n_tests++;
    if ({timer_sevseg1, timer_sevseg2, timer_sevseg3} !== {seg_of(5), seg_of(0), seg_of(0)}) begin
      n_fail++;
      $display("FAIL reset_sevseg: got %b_%b_%b expected 5:00", timer_sevseg1, timer_sevseg2, timer_sevseg3);
    end
    n_tests++;
    if (strike_leds !== 3'b000 || exploded !== 1'b0 || q !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_outputs: leds=%b exploded=%b q=%h expected 000 0 0000", strike_leds, exploded, q);
    end
    rd(A_STATUS, 16'h0000, "reset_status");
    rd(A_TIME, 16'h0500, "reset_time");
  endtask

  task automatic test_countdown();
    wr(A_TIME, 16'h0102);
    wr(A_CTRL, C_START);
    step(8);
    rd(A_TIME, 16'h0100, "count_0100");
    step(3);
    rd(A_TIME, 16'h0059, "count_0059");
    n_tests++;
    if ({timer_sevseg1, timer_sevseg2, timer_sevseg3} !== {seg_of(0), seg_of(5), seg_of(9)}) begin
      n_fail++;
      $display("FAIL count_sevseg: got %b_%b_%b expected 0:59", timer_sevseg1, timer_sevseg2, timer_sevseg3);
    end
    rd(A_STATUS, 16'h0004, "count_status_running");
    wr(A_CTRL, C_STOP);
    step(5);
    rd(A_TIME, 16'h0059, "stop_time_held");
    rd(A_STATUS, 16'h0000, "stop_status_idle");
    // Prescaler stopped at 3 of 0..3, so the resumed count ticks on the first running edge
    wr(A_CTRL, C_START);
    rd(A_TIME, 16'h0059, "resume_pretick_read");
    rd(A_TIME, 16'h0058, "resume_partial_second");
    wr(A_CTRL, C_CLEAR);
  endtask

  task automatic test_timeout();
    wr(A_TIME, 16'h0001);
    wr(A_CTRL, C_START);
    step(3);
    n_tests++;
    if (exploded !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_early: exploded=%b expected 0", exploded);
    end
    step(1);
    n_tests++;
    if (exploded !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_exploded: exploded=%b expected 1", exploded);
    end
    rd(A_STATUS, 16'h0008, "timeout_status");
    wr(A_CTRL, C_START);
    rd(A_STATUS, 16'h0008, "timeout_start_ignored");
    wr(A_TIME, 16'h0300);
    rd(A_TIME, 16'h0000, "timeout_time_write_ignored");
    wr(A_CTRL, C_CLEAR);
  endtask

  task automatic test_zero_start();
    wr(A_TIME, 16'h0000);
    wr(A_CTRL, C_START);
    n_tests++;
    if (exploded !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_start_early: exploded=%b expected 0", exploded);
    end
    step(1);
    n_tests++;
    if (exploded !== 1'b1) begin
      n_fail++;
      $display("FAIL zero_start_exploded: exploded=%b expected 1", exploded);
    end
    wr(A_CTRL, C_CLEAR);
  endtask

  task automatic test_strikes();
    logic [2:0] exp_leds [3] = '{3'b001, 3'b011, 3'b111};
    wr(A_CTRL, C_START);
    for (int i = 0; i < 3; i++) begin
      wr(A_CTRL, C_STRIKE);
      n_tests++;
      if (strike_leds !== exp_leds[i] || exploded !== (i == 2)) begin
        n_fail++;
        $display("FAIL strike_%0d: leds=%b exploded=%b expected %b %0d", i + 1, strike_leds, exploded,
                 exp_leds[i], (i == 2));
      end
    end
    rd(A_STATUS, 16'h000B, "strike_status");
    wr(A_CTRL, C_CLEAR);
    n_tests++;
    if (strike_leds !== 3'b000 || exploded !== 1'b0 ||
        {timer_sevseg1, timer_sevseg2, timer_sevseg3} !== {seg_of(5), seg_of(0), seg_of(0)}) begin
      n_fail++;
      $display("FAIL clear_outputs: leds=%b exploded=%b segs=%b_%b_%b expected 000 0 5:00",
               strike_leds, exploded, timer_sevseg1, timer_sevseg2, timer_sevseg3);
    end
    rd(A_STATUS, 16'h0000, "clear_status");
    // Strikes also count and can explode while idle
    repeat (3) wr(A_CTRL, C_STRIKE);
    rd(A_STATUS, 16'h000B, "idle_strike_status");
    wr(A_CTRL, C_CLEAR);
  endtask

  task automatic test_clamp();
    wr(A_TIME, 16'h0A7C);
    rd(A_TIME, 16'h0959, "clamp_idle");
    wr(A_CTRL, C_START);
    wr(A_TIME, 16'h0123);
    rd(A_TIME, 16'h0959, "clamp_running_ignored");
    n_tests++;
    if ({timer_sevseg1, timer_sevseg2, timer_sevseg3} !== {seg_of(9), seg_of(5), seg_of(9)}) begin
      n_fail++;
      $display("FAIL clamp_sevseg: got %b_%b_%b expected 9:59", timer_sevseg1, timer_sevseg2, timer_sevseg3);
    end
    wr(A_CTRL, C_CLEAR);
  endtask

  task automatic test_defuse();
    wr(A_TIME, 16'h0001);
    wr(A_CTRL, C_START);
    step(3);
    wr(A_CTRL, C_DEFUSE);
    rd(A_STATUS, 16'h0008, "defuse_vs_timeout");
    wr(A_CTRL, C_CLEAR);
    wr(A_CTRL, C_START);
    wr(A_CTRL, C_DEFUSE);
    rd(A_STATUS, 16'h000C, "defuse_status");
    step(10);
    rd(A_TIME, 16'h0500, "defuse_time_frozen");
    n_tests++;
    if (exploded !== 1'b0) begin
      n_fail++;
      $display("FAIL defuse_exploded: exploded=%b expected 0", exploded);
    end
    wr(A_CTRL, C_CLEAR);
  endtask

  task automatic test_read_path();
    rd(A_TIME, 16'h0500, "read_time");
    re = 1'b0; read_addr = A_STATUS;
    step(1);
    n_tests++;
    if (q !== 16'h0500) begin
      n_fail++;
      $display("FAIL read_hold: q=%h expected 0500", q);
    end
    rd(16'hFF03, 16'h0000, "read_unmapped");
    rd(A_CTRL, 16'h0000, "read_ctrl_zero");
    wr(16'hFF05, C_START);
    wr(16'h0000, C_STRIKE);
    rd(A_STATUS, 16'h0000, "unmapped_write_ignored");
  endtask

`ifdef KTANE_TIMER_STRIKE_SPEEDUP_EN
  task automatic test_speedup();
    wr(A_CTRL, C_CLEAR);
    wr(A_CTRL, C_STRIKE);
    wr(A_CTRL, C_STRIKE);
    wr(A_TIME, 16'h0010);
    wr(A_CTRL, C_START);
    step(2);
    rd(A_TIME, 16'h0009, "speedup_first");
    step(1);
    rd(A_TIME, 16'h0008, "speedup_second");
    wr(A_CTRL, C_CLEAR);
  endtask
`endif

  initial begin
    test_reset();
    test_countdown();
    test_timeout();
    test_zero_start();
    test_strikes();
    test_clamp();
    test_defuse();
    test_read_path();
`ifdef KTANE_TIMER_STRIKE_SPEEDUP_EN
    test_speedup();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/ktane_timer_periph.md
Name: ktane_timer_periph

Overview:
- Memory-mapped bomb countdown timer and strike counter on the CPU data bus, downstream of the CPU's store path.
- Consumes the CPU's write data, write address and write enable; returns read data to the memory read mux.
- Drives the three timer seven-segment digits (M:SS) and the three strike LEDs.
- Asserts `exploded` on timeout or on max strikes.

Parameters:
- CLK_HZ, 50000000, clock cycles per countdown second (a bench sets this small).
- BASE_ADDR, 16'hFF00, word address of register 0; the block decodes BASE_ADDR..BASE_ADDR+2.
- START_TIME, 12'h500, BCD M:SS loaded at reset and by CLEAR.
- MAX_STRIKES, 3, strike count that causes explosion (range 1..3).

Ports:
- clock, in, 1, system clock.
- reset, in, 1, synchronous, active-low.
- data, in, 16, CPU write data.
- write_addr, in, 16, CPU write address.
- we, in, 1, write strobe; one write per asserted cycle.
- read_addr, in, 16, CPU read address.
- re, in, 1, read enable.
- q, out, 16, registered read data.
- timer_sevseg1, out, 7, minutes digit, active-low {g,f,e,d,c,b,a}.
- timer_sevseg2, out, 7, tens-of-seconds digit.
- timer_sevseg3, out, 7, units-of-seconds digit.
- strike_leds, out, 3, thermometer code of the strike count.
- exploded, out, 1, high while in state EXPLODED.

Behaviour:
Register map (word offsets from BASE_ADDR):
- +0 CTRL, write-only, self-clearing bits: bit0 START, bit1 STOP, bit2 STRIKE, bit3 DEFUSE, bit4 CLEAR.
- +1 TIME, R/W: {4'b0, M, S10, S1} in BCD. A write is accepted only in IDLE.
  - On write, any digit over 9 clamps to 9; S10 over 5 clamps to 5.
- +2 STATUS, read-only: {12'b0, state[1:0], strikes[1:0]}.
- Writes to any other address are ignored.

Reset (reset==0 at a rising edge):
- state=IDLE, time=START_TIME, strikes=0, prescaler=0.
- q=0, strike_leds=0, exploded=0.
- Sevseg outputs show START_TIME one cycle after reset deasserts; they are combinational from the time register.

State machine:
- IDLE: START -> RUNNING. STRIKE increments strikes and can explode from IDLE.
- RUNNING:
  - STOP -> IDLE, time held.
  - DEFUSE -> DEFUSED.
  - The countdown reaching 0:00 -> EXPLODED.
  - strikes reaching MAX_STRIKES -> EXPLODED.
- EXPLODED and DEFUSED: terminal. All CTRL bits ignored except CLEAR.
- CLEAR in any state: -> IDLE, time=START_TIME, strikes=0, prescaler=0.
- CLEAR has highest priority among CTRL bits in the same write.

Prescaler:
- Counts 0..CLK_HZ-1 only in RUNNING; tick = wrap. Holds its value in IDLE.
- On START, the prescaler is not cleared, so a resumed count keeps its partial second.

Countdown:
- On tick, BCD decrement: S1 9..0, borrow into S10 5..0, borrow into M.
- 0:01 -> 0:00 and state=EXPLODED in the same edge.
- Time 0:00 at START: the block enters EXPLODED on the next cycle.

Strikes:
- Saturate at MAX_STRIKES.
- strike_leds = 3'b000, 001, 011, 111 for 0..3 strikes.

Simultaneous events in one cycle:
- Explosion beats DEFUSE.
- A STRIKE reaching MAX together with a tick: explosion.

Read path:
- q updates on the clock edge after re=1, giving 1-cycle latency.
- re=1 with an unmapped address: q=0.
- re=0: q holds its value.
- A read of TIME in the same cycle as a tick returns the pre-tick value.

Sevseg encoding (active-low):
- 0=7'b1000000
- 1=7'b1111001
- 2=7'b0100100
- 3=7'b0110000
- 4=7'b0011001
- 5=7'b0010010
- 6=7'b0000010
- 7=7'b1111000
- 8=7'b0000000
- 9=7'b0010000

Optional Feature:
- Macro: KTANE_TIMER_STRIKE_SPEEDUP_EN.
- Defined: the prescaler terminal count is CLK_HZ-1 minus (CLK_HZ/4)*strikes (1, 0.75, 0.5, 0.25 s per decrement).
  - If the prescaler is already beyond the new terminal count when a strike lands, the next cycle ticks and the prescaler wraps.
- Undefined: the terminal count is always CLK_HZ-1.

Decomposition:
- Package ktane_timer_pkg:
  - state encodings IDLE=2'd0, RUNNING=2'd1, EXPLODED=2'd2, DEFUSED=2'd3;
  - register offsets;
  - CTRL bit indices;
  - sevseg constant table.
- One sub-module, bcd_to_sevseg (4-bit in, 7-bit active-low out), instantiated three times.

Test Plan (all with CLK_HZ=4):
- Reset low 2 cycles, then high -> sevseg shows 5:00, strike_leds=000, exploded=0, read STATUS returns 16'h0000.
- Write TIME=16'h0102, CTRL=1 -> after 8 cycles read TIME=16'h0100; 4 more cycles -> 16'h0059.
- Write TIME=16'h0001 and START -> 4 cycles later exploded=1 and STATUS[3:2]=2'd2; a subsequent START is ignored.
- Three STRIKE writes while RUNNING -> strike_leds 001, 011, 111; exploded=1 on the third. CLEAR -> IDLE, 5:00, leds 000.
- Write TIME=16'h0A7C in IDLE -> readback 16'h0959. The same write while RUNNING is ignored.
- In the cycle the last tick hits 0:00, write DEFUSE -> state EXPLODED.
- With the macro defined, 2 strikes, then START from 0:10 -> decrements every 2 cycles.
